// File: rtl/strassen_pkg.sv
// Shared definitions for the Strassen 2x2 micro-sequencer.
// Covers opcodes, scratch register map, FSM states and the micro-op format.
package strassen_pkg;

    localparam int unsigned NUM_UOPS  = 25;
    localparam int unsigned NUM_REGS  = 24;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned UOP_OP_W  = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [UOP_OP_W-1:0]  uop_op_t;

    localparam uop_op_t OP_ADD = 3'd0;
    localparam uop_op_t OP_SUB = 3'd1;
    localparam uop_op_t OP_MUL = 3'd2;

    localparam reg_idx_t R_A11 = 5'd0;
    localparam reg_idx_t R_A12 = 5'd1;
    localparam reg_idx_t R_A21 = 5'd2;
    localparam reg_idx_t R_A22 = 5'd3;
    localparam reg_idx_t R_B11 = 5'd4;
    localparam reg_idx_t R_B12 = 5'd5;
    localparam reg_idx_t R_B21 = 5'd6;
    localparam reg_idx_t R_B22 = 5'd7;
    localparam reg_idx_t R_T0  = 5'd8;
    localparam reg_idx_t R_T1  = 5'd9;
    localparam reg_idx_t R_T2  = 5'd10;
    localparam reg_idx_t R_T3  = 5'd11;
    localparam reg_idx_t R_T4  = 5'd12;
    localparam reg_idx_t R_T5  = 5'd13;
    localparam reg_idx_t R_T6  = 5'd14;
    localparam reg_idx_t R_T7  = 5'd15;
    localparam reg_idx_t R_T8  = 5'd16;
    localparam reg_idx_t R_T9  = 5'd17;
    localparam reg_idx_t R_M1  = 5'd18;
    localparam reg_idx_t R_M2  = 5'd19;
    localparam reg_idx_t R_M3  = 5'd20;
    localparam reg_idx_t R_M4  = 5'd21;
    localparam reg_idx_t R_M5  = 5'd22;
    localparam reg_idx_t R_M6  = 5'd23;
    // M7 and the C outputs overwrite temporaries that are dead by then.
    localparam reg_idx_t R_M7  = R_T0;
    localparam reg_idx_t R_C11 = R_T1;
    localparam reg_idx_t R_C12 = R_T2;
    localparam reg_idx_t R_C21 = R_T3;
    localparam reg_idx_t R_C22 = R_T4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        reg_idx_t src_a;
        reg_idx_t src_b;
        reg_idx_t dst;
        uop_op_t  op;
    } uop_t;

    function automatic uop_t mk_uop(reg_idx_t src_a, reg_idx_t src_b, reg_idx_t dst, uop_op_t op);
        uop_t u;
        u.src_a = src_a;
        u.src_b = src_b;
        u.dst   = dst;
        u.op    = op;
        return u;
    endfunction

endpackage

// File: rtl/strassen_uop_rom.sv
// Combinational step -> micro-op table for the 25-step Strassen schedule.
import strassen_pkg::*;

module strassen_uop_rom (
    input  logic [REG_IDX_W-1:0] step,
    output uop_t                 uop
);

    always_comb begin
        uop = '0;
        case (step)
            5'd0:  uop = mk_uop(R_A11, R_A22, R_T0,  OP_ADD);
            5'd1:  uop = mk_uop(R_B11, R_B22, R_T1,  OP_ADD);
            5'd2:  uop = mk_uop(R_A21, R_A22, R_T2,  OP_ADD);
            5'd3:  uop = mk_uop(R_B12, R_B22, R_T3,  OP_SUB);
            5'd4:  uop = mk_uop(R_B21, R_B11, R_T4,  OP_SUB);
            5'd5:  uop = mk_uop(R_A11, R_A12, R_T5,  OP_ADD);
            5'd6:  uop = mk_uop(R_A21, R_A11, R_T6,  OP_SUB);
            5'd7:  uop = mk_uop(R_B11, R_B12, R_T7,  OP_ADD);
            5'd8:  uop = mk_uop(R_A12, R_A22, R_T8,  OP_SUB);
            5'd9:  uop = mk_uop(R_B21, R_B22, R_T9,  OP_ADD);
            5'd10: uop = mk_uop(R_T0,  R_T1,  R_M1,  OP_MUL);
            5'd11: uop = mk_uop(R_T2,  R_B11, R_M2,  OP_MUL);
            5'd12: uop = mk_uop(R_A11, R_T3,  R_M3,  OP_MUL);
            5'd13: uop = mk_uop(R_A22, R_T4,  R_M4,  OP_MUL);
            5'd14: uop = mk_uop(R_T5,  R_B22, R_M5,  OP_MUL);
            5'd15: uop = mk_uop(R_T6,  R_T7,  R_M6,  OP_MUL);
            5'd16: uop = mk_uop(R_T8,  R_T9,  R_M7,  OP_MUL);
            5'd17: uop = mk_uop(R_M1,  R_M4,  R_C11, OP_ADD);
            5'd18: uop = mk_uop(R_C11, R_M5,  R_C11, OP_SUB);
            5'd19: uop = mk_uop(R_C11, R_M7,  R_C11, OP_ADD);
            5'd20: uop = mk_uop(R_M3,  R_M5,  R_C12, OP_ADD);
            5'd21: uop = mk_uop(R_M2,  R_M4,  R_C21, OP_ADD);
            5'd22: uop = mk_uop(R_M1,  R_M2,  R_C22, OP_SUB);
            5'd23: uop = mk_uop(R_C22, R_M3,  R_C22, OP_ADD);
            5'd24: uop = mk_uop(R_C22, R_M6,  R_C22, OP_ADD);
            default: uop = '0;
        endcase
    end

endmodule

// File: rtl/strassen_seq.sv
// Sequencer issuing one external ALU op per cycle to form a 2x2 Strassen product.
import strassen_pkg::*;

module strassen_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] in_a,
    input  logic [4*DATA_W-1:0] in_b,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DATA_W-1:0] out_c,
    output logic                busy
);

    state_t                state_q, state_d;
    logic [REG_IDX_W-1:0]  step_q, step_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    uop_t                  uop;

    strassen_uop_rom u_rom (
        .step (step_q),
        .uop  (uop)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        regs_d  = regs_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        regs_d[REG_IDX_W'(i)]     = in_a[i*DATA_W +: DATA_W];
                        regs_d[REG_IDX_W'(i + 4)] = in_b[i*DATA_W +: DATA_W];
                    end
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_a            = regs_q[uop.src_a];
                alu_b            = regs_q[uop.src_b];
                alu_op           = OP_W'(uop.op);
                regs_d[uop.dst]  = alu_result;
                step_d           = step_q + 5'd1;
                if (step_q == REG_IDX_W'(NUM_UOPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            regs_q  <= regs_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_c     = (state_q == DONE)
                     ? {regs_q[R_C22], regs_q[R_C21], regs_q[R_C12], regs_q[R_C11]}
                     : '0;

endmodule

// File: tb/tb_strassen_seq.sv
// Directed bench for strassen_seq with a behavioural ALU and hand-computed products.
module tb_strassen_seq;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] in_a;
    logic [4*DW-1:0] in_b;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [2:0]      alu_op;
    logic [DW-1:0]   alu_result;
    logic            out_valid;
    logic            out_ready;
    logic [4*DW-1:0] out_c;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    strassen_seq #(.DATA_W(32), .OP_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a * alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input int e11, input int e12, input int e21, input int e22);
        return {32'(e22), 32'(e21), 32'(e12), 32'(e11)};
    endfunction

    logic [127:0] s1_a, s1_b, s1_c, s2_a, s2_b, s2_c, s3_a, s3_b, s3_c;
    logic [74:0]  s2_ops;
    int           op_seq [25] = '{0, 0, 0, 1, 1, 0, 1, 0, 1, 0,
                                  2, 2, 2, 2, 2, 2, 2,
                                  0, 1, 0, 0, 0, 1, 0, 0};

    task automatic run_job(input string tag, input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] exp, input int hold, input bit chk_ops,
                           input logic [74:0] exp_ops);
        int          n;
        int          nops;
        logic [74:0] ops;
        @(negedge clk);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n    = 1;
        nops = 0;
        ops  = '0;
        while (!out_valid && n < 60) begin
            if (busy && nops < 25) begin
                ops[nops*3 +: 3] = alu_op;
                nops++;
            end
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 128'(n), 128'(26));
        chk({tag, "_out_c"}, out_c, exp);
        chk({tag, "_alu_quiet"}, {alu_a, alu_b, alu_op}, '0);
        if (chk_ops) chk({tag, "_ops"}, 128'(ops), 128'(exp_ops));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {out_c, 1'b0}, {exp, 1'b0});
            chk({tag, "_hold_flags"}, {in_ready, out_valid}, 128'(2'b01));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {in_ready, out_valid}, 128'(2'b10));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        int           vcount;
        int           tacc [3];
        logic [127:0] ja [3];
        logic [127:0] jb [3];
        logic [127:0] je [3];

        s1_a = pack4(1, 2, 3, 4);
        s1_b = pack4(5, 6, 7, 8);
        s1_c = pack4(19, 22, 43, 50);
        s2_a = pack4(-1, 0, 0, -1);
        s2_b = pack4(2, 3, 4, 5);
        s2_c = pack4(-2, -3, -4, -5);
        s3_a = pack4(32'h0001_0000, 0, 0, 0);
        s3_b = pack4(32'h0001_0000, 0, 0, 0);
        s3_c = '0;
        s2_ops = '0;
        for (int i = 0; i < 25; i++) s2_ops[i*3 +: 3] = 3'(op_seq[i]);

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {in_ready, busy, out_valid}, 128'(3'b100));
        chk("reset_out_c", out_c, '0);
        chk("reset_alu", {alu_a, alu_b, alu_op}, '0);
        reset = 1'b0;

        run_job("s1", s1_a, s1_b, s1_c, 0, 1'b0, '0);
        run_job("s2", s2_a, s2_b, s2_c, 0, 1'b1, s2_ops);
        run_job("s3_wrap", s3_a, s3_b, s3_c, 0, 1'b0, '0);
        run_job("s4_stall", s1_a, s1_b, s1_c, 10, 1'b0, '0);

        // Abort a job at step 12, then confirm nothing leaks out.
        @(negedge clk);
        in_a     = s1_a;
        in_b     = s1_b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_busy", 128'(busy), 128'(1));
        reset = 1'b1;
        #1;
        chk("abort_flags", {in_ready, busy, out_valid}, 128'(3'b100));
        chk("abort_out_c", out_c, '0);
        @(negedge clk);
        reset  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("abort_no_valid", 128'(vcount), 128'(0));
        run_job("s5_after_abort", s2_a, s2_b, s2_c, 0, 1'b1, s2_ops);

        ja[0] = s1_a; jb[0] = s1_b; je[0] = s1_c;
        ja[1] = s2_a; jb[1] = s2_b; je[1] = s2_c;
        ja[2] = s3_a; jb[2] = s3_b; je[2] = s3_c;
        out_ready = 1'b1;
        @(negedge clk);
        in_a     = ja[0];
        in_b     = jb[0];
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n = 0;
            while (!in_ready && n < 60) begin
                @(negedge clk);
                n++;
            end
            tacc[j] = cyc;
            @(posedge clk);
            @(negedge clk);
            if (j < 2) begin
                in_a = ja[j+1];
                in_b = jb[j+1];
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("b2b_out_c%0d", j), out_c, je[j]);
        end
        chk("b2b_space01", 128'(tacc[1] - tacc[0]), 128'(27));
        chk("b2b_space12", 128'(tacc[2] - tacc[1]), 128'(27));
        @(negedge clk);
        chk("b2b_idle", {in_ready, busy, out_valid}, 128'(3'b100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
